sram_march_bist: RTL and testbench
==================================

# sram_march_bist

Built-in self-test initiator for one port of the 1024x18 dual-port SRAM macro. It drives the macro's active-low chip-enable, write-enable and write-mask port signals, and runs a March C- sequence over all 1024 words. It compares every read against the expected background and reports pass/fail with first-failure capture. It sits between the macro port mux and the chip test controller; functional logic drives the port whenever `busy` is low.

## Interface
- `DATA_BG`, 18'h00000: background pattern; "0" = `DATA_BG`, "1" = `~DATA_BG`
- `CNT_W`, 8: width of the saturating failure counter
- Clock is `clk`; reset is `rst_n`, asynchronous and active-low.
- `clk`  in  1  clock; the SRAM port clock is the same net
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  pulse; starts a test when not busy
- `busy`  out  1  test in progress; the macro port is owned by BIST
- `done`  out  1  level; test finished; cleared by the next accepted `start`
- `fail`  out  1  sticky; at least one miscompare seen
- `fail_addr`  out  10  address of the first miscompare
- `fail_syndrome`  out  18  rdata XOR expected at the first miscompare
- `fail_count`  out  CNT_W  miscompares, saturating at all-ones
- `cen`  out  1  SRAM chip enable, active low
- `wen`  out  1  SRAM write enable, active low (0 = write)
- `addr`  out  10  SRAM address
- `wmsk`  out  18  SRAM write mask; 1 = keep bit; held at 0
- `wdata`  out  18  SRAM write data
- `rdata`  in  18  SRAM read data

## Operation
- Macro contract:
  - The macro registers `cen/wen/addr/wmsk/wdata` at posedge N.
  - Read data for an access registered at posedge N is valid, and is sampled by BIST, at posedge N+1.
- States:
  - IDLE: `cen`=1, `wen`=1.
  - RUN: tracks element index E (0..5), address A, and phase P (read/write).
  - DRAIN: one cycle to compare the last read.
  - DONE.
- March C- elements (BG = `DATA_BG`, ~BG = its complement):
  - M0: ascending, w BG.
  - M1: ascending, r BG then w ~BG.
  - M2: ascending, r ~BG then w BG.
  - M3: descending, r BG then w ~BG.
  - M4: descending, r ~BG then w BG.
  - M5: ascending, r BG.
- Per-element issue pattern:
  - M0 and M5 issue one access per cycle.
  - M1–M4 issue a read at A, then a write at A in the next cycle, then move to the next address.
- Addressing: ascending runs 0x000→0x3FF and descending runs 0x3FF→0x000. At the last address, A reloads the start address of the next element; there is no idle cycle between elements.
- Compare pipeline:
  - Each issued read registers an expected value and its address.
  - The compare happens one posedge later: in the write cycle for M1–M4, and against the next M5 read, or in DRAIN for the last M5 read.
- Miscompare handling:
  - Every miscompare sets `fail` and increments `fail_count` (saturating).
  - Only the first miscompare loads `fail_addr` and `fail_syndrome`; later ones do not overwrite them.
- `start` while busy is ignored. `start` in DONE restarts the test: it clears `done`, `fail`, `fail_count`, `fail_addr` and `fail_syndrome`.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `fail`=0.
  - `fail_addr`=0, `fail_syndrome`=0, `fail_count`=0.
  - `cen`=1, `wen`=1, `addr`=0, `wmsk`=0, `wdata`=0.
  - State is IDLE.
- Start sequence: `start` is sampled high at posedge S (IDLE or DONE). `busy`=1 after S, and the first M0 write is driven in the cycle after S.
- Length: 1024 + 4×2048 + 1024 = 10240 access cycles, plus 1 DRAIN cycle.
- End of test:
  - `done` rises and `busy` falls at posedge S+10241.
  - `cen`=1 from the cycle after the last M5 read onward.
- Reset mid-run: all outputs return to reset values immediately (asynchronous). The test does not resume. The SRAM sees no further enabled access.
- `cen`=0 in every RUN cycle. `wen`=0 exactly on write cycles.

## Test plan
- Fault-free behavioral SRAM, default BG, pulse `start`:
  - `busy` for 10241 cycles, then `done`=1.
  - `fail`=0, `fail_count`=0.
  - 5120 reads and 5120 writes observed.
- Bit 5 at address 0x155 stuck-at-1, BG=0:
  - `fail`=1, `fail_addr`=0x155, `fail_syndrome`=0x00020.
  - `fail_count`=3 (M1, M3 and M5 reads).
- Address-order monitor:
  - M3 issues 0x3FF, 0x3FF, 0x3FE, … 0x000 (read/write pairs).
  - Next cycle is an M4 read at 0x3FF.
- `DATA_BG`=18'h2AAAA with a fault-free memory: M0 writes 0x2AAAA, M1 writes 0x15555, and the test passes.
- Behaviour of `start`:
  - `start` pulsed mid-run: no effect; total length is still 10241.
  - `start` after DONE with a previous fail: all status clears and the test reruns.
- `rst_n` low at cycle 3000:
  - `cen`=1 and `busy`=0 asynchronously.
  - After release, outputs stay idle until `start`.

Source files
------------

// File: rtl/sram_march_bist.sv
// March C- built-in self-test initiator for one port of the 1024x18 dual-port SRAM macro,
// with sticky pass/fail status, saturating miscompare count and first-failure capture.
module sram_march_bist #(
    parameter logic [17:0] DATA_BG = 18'h00000,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [9:0]       fail_addr,
    output logic [17:0]      fail_syndrome,
    output logic [CNT_W-1:0] fail_count,
    output logic             cen,
    output logic             wen,
    output logic [9:0]       addr,
    output logic [17:0]      wmsk,
    output logic [17:0]      wdata,
    input  logic [17:0]      rdata
);
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 18;
    localparam logic [AW-1:0] ADDR_TOP  = '1;
    localparam logic [2:0]    ELEM_LAST = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [2:0]     elem;
    logic           cmp_valid;
    logic [DW-1:0]  cmp_exp;
    logic [AW-1:0]  cmp_addr;

    logic           descending;
    logic           paired;
    logic           last_addr;
    logic [AW-1:0]  step_addr;
    logic [AW-1:0]  next_start;
    logic [DW-1:0]  rd_exp;
    logic [DW-1:0]  wr_val;
    logic [DW-1:0]  syndrome;
    logic           miscompare;

    // Per-element addressing direction and data polarity of the current access.
    always_comb begin
        descending = (elem == 3'd3) || (elem == 3'd4);
        paired     = (elem != 3'd0) && (elem != ELEM_LAST);
        last_addr  = descending ? (addr == '0) : (addr == ADDR_TOP);
        step_addr  = descending ? (addr - AW'(1)) : (addr + AW'(1));
        next_start = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_TOP : '0;
        rd_exp     = ((elem == 3'd2) || (elem == 3'd4)) ? ~DATA_BG : DATA_BG;
        wr_val     = ((elem == 3'd1) || (elem == 3'd3)) ? ~DATA_BG : DATA_BG;
        syndrome   = rdata ^ cmp_exp;
        miscompare = cmp_valid && (syndrome != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            elem          <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_addr     <= '0;
            fail_syndrome <= '0;
            fail_count    <= '0;
            cen           <= 1'b1;
            wen           <= 1'b1;
            addr          <= '0;
            wmsk          <= '0;
            wdata         <= '0;
            cmp_valid     <= 1'b0;
            cmp_exp       <= '0;
            cmp_addr      <= '0;
        end else begin
            // Read data for the access registered one edge ago is compared here.
            cmp_valid <= 1'b0;
            if (miscompare) begin
                fail <= 1'b1;
                if (fail_count != '1) begin
                    fail_count <= fail_count + CNT_W'(1);
                end
                if (!fail) begin
                    fail_addr     <= cmp_addr;
                    fail_syndrome <= syndrome;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        fail          <= 1'b0;
                        fail_count    <= '0;
                        fail_addr     <= '0;
                        fail_syndrome <= '0;
                        elem          <= 3'd0;
                        cen           <= 1'b0;
                        wen           <= 1'b0;
                        addr          <= '0;
                        wdata         <= DATA_BG;
                    end
                end
                S_RUN: begin
                    if (wen) begin
                        cmp_valid <= 1'b1;
                        cmp_exp   <= rd_exp;
                        cmp_addr  <= addr;
                    end
                    if (paired && wen) begin
                        wen   <= 1'b0;
                        wdata <= wr_val;
                    end else if (!last_addr) begin
                        addr <= step_addr;
                        wen  <= (elem != 3'd0);
                    end else if (elem == ELEM_LAST) begin
                        state <= S_DRAIN;
                        cen   <= 1'b1;
                        wen   <= 1'b1;
                    end else begin
                        // Every element after M0 opens with a read at its start address.
                        elem <= elem + 3'd1;
                        addr <= next_start;
                        wen  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Randomized stuck-at fault bench for sram_march_bist: behavioural SRAM, March C- access
// enumeration and fault-outcome model computed directly from the algorithm.
module tb_sram_march_bist;
    localparam int N_ACC   = 10240;
    localparam int RUN_CYC = 10241;
    localparam int N_RD    = 5120;
    localparam int N_WR    = 5120;
    localparam logic [17:0] BG_A = 18'h00000;
    localparam logic [17:0] BG_B = 18'h2AAAA;

    typedef struct packed {
        logic        we;
        logic [9:0]  a;
        logic [17:0] d;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    logic        a_busy, a_done, a_fail, a_cen, a_wen;
    logic [9:0]  a_fail_addr, a_addr;
    logic [17:0] a_syn, a_wmsk, a_wdata, a_rdata;
    logic [7:0]  a_cnt;

    logic        b_busy, b_done, b_fail, b_cen, b_wen;
    logic [9:0]  b_fail_addr, b_addr;
    logic [17:0] b_syn, b_wmsk, b_wdata, b_rdata;
    logic [7:0]  b_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    bit          f_en;
    logic [9:0]  f_addr;
    int          f_bit;
    bit          f_val;

    logic [17:0] mem_a [1024];
    logic [17:0] mem_b [1024];

    always #5 clk = ~clk;

    sram_march_bist #(.DATA_BG(BG_A), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(a_busy), .done(a_done), .fail(a_fail),
        .fail_addr(a_fail_addr), .fail_syndrome(a_syn), .fail_count(a_cnt),
        .cen(a_cen), .wen(a_wen), .addr(a_addr), .wmsk(a_wmsk), .wdata(a_wdata),
        .rdata(a_rdata)
    );

    sram_march_bist #(.DATA_BG(BG_B), .CNT_W(8)) dut_bg (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(b_busy), .done(b_done), .fail(b_fail),
        .fail_addr(b_fail_addr), .fail_syndrome(b_syn), .fail_count(b_cnt),
        .cen(b_cen), .wen(b_wen), .addr(b_addr), .wmsk(b_wmsk), .wdata(b_wdata),
        .rdata(b_rdata)
    );

    function automatic logic [17:0] apply_fault(input logic [17:0] v, input logic [9:0] a,
                                                input bit en, input logic [9:0] fa,
                                                input int fb, input bit fv);
        logic [17:0] bitm;
        bitm = 18'(1) << fb;
        if (!en || a != fa) return v;
        return fv ? (v | bitm) : (v & ~bitm);
    endfunction

    // k-th access of March C-: M0 w, M1..M4 r/w pairs (M3/M4 descending), M5 r.
    function automatic acc_t exp_access(input int k, input logic [17:0] bg);
        acc_t x;
        int j, e, i;
        if (k < 1024) begin
            x.we = 1'b1; x.a = 10'(k); x.d = bg;
        end else if (k < 9216) begin
            j = k - 1024;
            e = 1 + j / 2048;
            i = (j % 2048) / 2;
            x.we = ((j % 2) == 1);
            x.a  = (e >= 3) ? 10'(1023 - i) : 10'(i);
            x.d  = x.we ? (((e % 2) == 1) ? ~bg : bg) : (((e % 2) == 1) ? bg : ~bg);
        end else begin
            x.we = 1'b0; x.a = 10'(k - 9216); x.d = bg;
        end
        return x;
    endfunction

    function automatic bit acc_ok(input int idx, input logic [17:0] bg, input logic busy,
                                  input logic wen, input logic [9:0] a,
                                  input logic [17:0] msk, input logic [17:0] d);
        acc_t x;
        if (idx >= N_ACC) return 1'b0;
        x = exp_access(idx, bg);
        if (!busy || (wen != !x.we) || (a != x.a) || (msk != '0)) return 1'b0;
        return !x.we || (d == x.d);
    endfunction

    // Outcome of a full March C- over a memory with one stuck bit.
    task automatic model_run(input logic [17:0] bg, input bit en, input logic [9:0] fa,
                             input int fb, input bit fv, output int cnt,
                             output logic [9:0] faddr, output logic [17:0] fsyn);
        logic [17:0] m [1024];
        acc_t x;
        logic [17:0] v;
        cnt = 0; faddr = '0; fsyn = '0;
        for (int k = 0; k < N_ACC; k++) begin
            x = exp_access(k, bg);
            if (x.we) begin
                m[x.a] = x.d;
            end else begin
                v = apply_fault(m[x.a], x.a, en, fa, fb, fv);
                if (v != x.d) begin
                    if (cnt == 0) begin
                        faddr = x.a;
                        fsyn  = v ^ x.d;
                    end
                    cnt++;
                end
            end
        end
    endtask

    // Behavioural macros: registered access, read data one edge later.
    always @(posedge clk) begin
        if (!a_cen) begin
            if (!a_wen) mem_a[a_addr] <= (a_wdata & ~a_wmsk) | (mem_a[a_addr] & a_wmsk);
            else        a_rdata <= apply_fault(mem_a[a_addr], a_addr, f_en, f_addr, f_bit, f_val);
        end
    end

    always @(posedge clk) begin
        if (!b_cen) begin
            if (!b_wen) mem_b[b_addr] <= (b_wdata & ~b_wmsk) | (mem_b[b_addr] & b_wmsk);
            else        b_rdata <= mem_b[b_addr];
        end
    end

    int a_idx = 0, a_rd = 0, a_wr = 0, a_err = 0, a_stray = 0;
    bit a_busy_d = 1'b0;
    always @(negedge clk) begin
        if (a_busy && !a_busy_d) begin
            a_idx = 0; a_rd = 0; a_wr = 0; a_err = 0;
        end
        a_busy_d = a_busy;
        if (!a_cen) begin
            if (!a_busy) a_stray++;
            if (!acc_ok(a_idx, BG_A, a_busy, a_wen, a_addr, a_wmsk, a_wdata)) a_err++;
            if (a_wen) a_rd++; else a_wr++;
            a_idx++;
        end
    end

    int b_idx = 0, b_rd = 0, b_wr = 0, b_err = 0, b_stray = 0;
    bit b_busy_d = 1'b0;
    logic [17:0] b_m0 = '0, b_m1 = '0;
    always @(negedge clk) begin
        if (b_busy && !b_busy_d) begin
            b_idx = 0; b_rd = 0; b_wr = 0; b_err = 0;
        end
        b_busy_d = b_busy;
        if (!b_cen) begin
            if (!b_busy) b_stray++;
            if (!acc_ok(b_idx, BG_B, b_busy, b_wen, b_addr, b_wmsk, b_wdata)) b_err++;
            if (b_idx == 0)    b_m0 = b_wdata;
            if (b_idx == 1025) b_m1 = b_wdata;
            if (b_wen) b_rd++; else b_wr++;
            b_idx++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_march(input string tag, input int poke_at);
        int cycles = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_start_busy"}, 32'(a_busy), 32'd1);
        check({tag, "_start_done"}, 32'(a_done), 32'd0);
        check({tag, "_start_status"}, 32'({a_fail, a_cnt, a_fail_addr}), 32'd0);
        check({tag, "_start_syn"}, 32'(a_syn), 32'd0);
        for (int i = 0; i < RUN_CYC + 100 && !a_done; i++) begin
            if (a_busy) cycles++;
            start = (i == poke_at);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done"}, 32'(a_done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(cycles), 32'(RUN_CYC));
        check({tag, "_end_idle"}, 32'({a_busy, a_cen, a_wen}), 32'b011);
        check({tag, "_reads"}, 32'(a_rd), 32'(N_RD));
        check({tag, "_writes"}, 32'(a_wr), 32'(N_WR));
        check({tag, "_seq_errs"}, 32'(a_err), 32'd0);
    endtask

    task automatic check_status(input string tag);
        int          cnt;
        logic [9:0]  faddr;
        logic [17:0] fsyn;
        model_run(BG_A, f_en, f_addr, f_bit, f_val, cnt, faddr, fsyn);
        check({tag, "_fail"}, 32'(a_fail), 32'(cnt != 0));
        check({tag, "_fail_count"}, 32'(a_cnt), 32'(cnt > 255 ? 255 : cnt));
        check({tag, "_fail_addr"}, 32'(a_fail_addr), 32'(faddr));
        check({tag, "_fail_syndrome"}, 32'(a_syn), 32'(fsyn));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        f_en = 1'b0; f_addr = '0; f_bit = 0; f_val = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_flags", 32'({a_busy, a_done, a_fail}), 32'd0);
        check("rst_fail_addr", 32'(a_fail_addr), 32'd0);
        check("rst_fail_syndrome", 32'(a_syn), 32'd0);
        check("rst_fail_count", 32'(a_cnt), 32'd0);
        check("rst_cen_wen", 32'({a_cen, a_wen}), 32'b11);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_wmsk", 32'(a_wmsk), 32'd0);
        check("rst_wdata", 32'(a_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_access", 32'(a_stray), 32'd0);

        run_march("clean", -1);
        check_status("clean");
        check("bg_done", 32'({b_done, b_fail}), 32'b10);
        check("bg_fail_count", 32'(b_cnt), 32'd0);
        check("bg_seq_errs", 32'(b_err), 32'd0);
        check("bg_reads", 32'(b_rd), 32'(N_RD));
        check("bg_m0_wdata", 32'(b_m0), 32'h2AAAA);
        check("bg_m1_wdata", 32'(b_m1), 32'h15555);

        f_en = 1'b1; f_addr = 10'h155; f_bit = 5; f_val = 1'b1;
        run_march("stuck155", -1);
        check_status("stuck155");
        check("stuck155_addr_const", 32'(a_fail_addr), 32'h155);
        check("stuck155_syn_const", 32'(a_syn), 32'h00020);
        check("stuck155_count_const", 32'(a_cnt), 32'd3);

        for (int t = 0; t < 3; t++) begin
            f_addr = 10'($urandom_range(0, 1023));
            f_bit  = int'($urandom_range(0, 17));
            f_val  = 1'($urandom_range(0, 1));
            run_march($sformatf("rand%0d", t), (t == 1) ? int'($urandom_range(200, 9000)) : -1);
            check_status($sformatf("rand%0d", t));
        end

        f_en = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2999) @(negedge clk);
        check("midrun_busy", 32'({a_busy, a_cen}), 32'b10);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_cen_busy", 32'({a_cen, a_busy, a_wen}), 32'b101);
        check("async_rst_status", 32'({a_done, a_fail, a_cnt}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("post_rst_idle", 32'({a_busy, a_done, a_cen}), 32'b001);
        check("post_rst_no_access", 32'(a_stray + b_stray), 32'd0);

        run_march("after_rst", -1);
        check_status("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
